// File: rtl/branch_pc_unit_if.sv
// branch_pc_unit_if: decode-side inputs and fetch/status outputs of the branch PC unit
interface branch_pc_unit_if #(
    parameter int PC_W      = 12,
    parameter int DATA_W    = 16,
    parameter int RAS_DEPTH = 4
);
    logic                        exec;
    logic                        stall;
    logic [DATA_W-1:0]           dec_ir;
    logic [PC_W-1:0]             dec_pc;
    logic [3:0]                  szcv;
    logic [PC_W-1:0]             fetch_pc;
    logic                        flush;
    logic                        halting;
    logic                        running;
    logic [$clog2(RAS_DEPTH):0]  ras_count;
    logic                        ras_overflow;
    logic                        ras_underflow;

    modport master (
        output exec, stall, dec_ir, dec_pc, szcv,
        input  fetch_pc, flush, halting, running, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  exec, stall, dec_ir, dec_pc, szcv,
        output fetch_pc, flush, halting, running, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch PC owner resolving B/Bcc/BAL/BR with a circular return-address stack
// and run/halt control; taken branches flush the single wrong-path decode slot.
module branch_pc_unit #(
    parameter int              PC_W      = 12,
    parameter int              DATA_W    = 16,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input logic             clock,
    input logic             reset,
    branch_pc_unit_if.slave bus
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2;

    logic [1:0]        state;
    logic [PC_W-1:0]   pc;
    logic              fl, ovf, unf;
    logic [AW-1:0]     sp;
    logic [CW-1:0]     cnt;
    logic [PC_W-1:0]   ras [RAS_DEPTH];
    logic [DATA_W-1:0] ir;
    logic              s, z, v, unused_c;
    logic              is_cond, cond_true, taken, is_bal, is_br, is_halt;
    logic              active, full, empty, do_push, do_pop, do_halt, br_empty;
    logic [PC_W-1:0]   target, ret_pc, inc;

    assign ir = bus.dec_ir;

    always_comb begin
        s         = bus.szcv[3];
        z         = bus.szcv[2];
        unused_c  = bus.szcv[1];
        v         = bus.szcv[0];
        is_cond   = ir[15:10] == 6'b101110;
        cond_true = ir[9] ? (ir[8] ? !z : (z || (s ^ v))) : (ir[8] ? (s ^ v) : z);
        taken     = ir[15:11] == 5'b10100 || (is_cond && cond_true);
        is_bal    = ir[15:11] == 5'b10110;
        is_br     = ir[15:11] == 5'b10101;
        is_halt   = ir[15:14] == 2'b11 && ir[7:4] == 4'hf;
        full      = cnt == CW'(RAS_DEPTH);
        empty     = cnt == '0;
        // decode is honoured only in RUN, unstalled, and not on the wrong-path slot
        active    = state == RUN && !bus.stall && !fl;
        do_push   = active && is_bal;
        do_pop    = active && is_br && !empty;
        br_empty  = active && is_br && empty;
        do_halt   = active && is_halt;
        target    = bus.dec_pc + {{(PC_W-8){ir[7]}}, ir[7:0]};
        ret_pc    = ras[sp - AW'(1)];
        inc       = pc + PC_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            fl    <= 1'b0;
            sp    <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (state != RUN) begin
            if (bus.exec) state <= RUN;
        end else if (!bus.stall) begin
            fl <= active && (taken || is_bal || do_pop);
            pc <= !active ? inc : (taken || is_bal) ? target : do_pop ? ret_pc : do_halt ? pc : inc;
            if (do_halt) state <= HALTED;
            if (do_push) begin
                sp  <= sp + AW'(1);
                cnt <= cnt + CW'(!full);
                ovf <= ovf || full;
            end
            if (do_pop) begin
                sp  <= sp - AW'(1);
                cnt <= cnt - CW'(1);
            end
            if (br_empty) unf <= 1'b1;
        end
    end

    // when full, sp already points at the oldest entry, so a push overwrites it
    always_ff @(posedge clock) begin
        if (do_push) ras[sp] <= bus.dec_pc + PC_W'(1);
    end

    assign bus.fetch_pc      = pc;
    assign bus.flush         = fl;
    assign bus.halting       = state == HALTED;
    assign bus.running       = state == RUN;
    assign bus.ras_count     = cnt;
    assign bus.ras_overflow  = ovf;
    assign bus.ras_underflow = unf;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: vector table plus hand sequences, expectations queued and compared after each edge
module tb_branch_pc_unit;
    typedef struct packed {
        logic [11:0] pc;
        logic        fl;
        logic        run;
        logic        halt;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } obs_t;

    typedef struct {
        logic        exec;
        logic        stall;
        logic [15:0] ir;
        logic [11:0] dpc;
        logic [3:0]  szcv;
        logic [11:0] pc;
        logic        fl;
        logic [2:0]  cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   failed = 0;
    obs_t sb [$];
    vec_t tbl [33];

    branch_pc_unit_if #(.PC_W(12), .DATA_W(16), .RAS_DEPTH(4)) bus ();
    branch_pc_unit #(.PC_W(12), .DATA_W(16), .RAS_DEPTH(4), .RESET_PC(12'h000)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    function automatic obs_t mk(logic [11:0] pc, logic fl, logic run, logic halt,
                                logic [2:0] cnt, logic ovf, logic unf);
        return {pc, fl, run, halt, cnt, ovf, unf};
    endfunction

    task automatic check(string name);
        obs_t e, a;
        tests++;
        if (sb.size() == 0) begin
            failed++;
            $display("FAIL %s: got empty scoreboard, want an expected record", name);
            return;
        end
        e = sb.pop_front();
        a = {bus.fetch_pc, bus.flush, bus.running, bus.halting, bus.ras_count,
             bus.ras_overflow, bus.ras_underflow};
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got pc=%h fl=%b run=%b halt=%b cnt=%0d ovf=%b unf=%b, want pc=%h fl=%b run=%b halt=%b cnt=%0d ovf=%b unf=%b",
                     name, a.pc, a.fl, a.run, a.halt, a.cnt, a.ovf, a.unf,
                     e.pc, e.fl, e.run, e.halt, e.cnt, e.ovf, e.unf);
        end
    endtask

    task automatic apply(logic ex, logic st, logic [15:0] ir, logic [11:0] dpc,
                         logic [3:0] f, obs_t e, string name);
        bus.exec   = ex;
        bus.stall  = st;
        bus.dec_ir = ir;
        bus.dec_pc = dpc;
        bus.szcv   = f;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check(name);
    endtask

    initial begin
        logic [11:0] ret;
        tbl = '{
            '{1'b1, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd0,    1'b0, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd1,    1'b0, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd2,    1'b0, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd3,    1'b0, 3'd0},
            '{1'b0, 1'b1, 16'h0000, 12'd0,    4'h0, 12'd3,    1'b0, 3'd0},
            '{1'b0, 1'b1, 16'h0000, 12'd0,    4'h0, 12'd3,    1'b0, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd4,    1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hBBFC, 12'd5,    4'h0, 12'd1,    1'b1, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd2,    1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hBBFC, 12'd5,    4'h4, 12'd3,    1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hB805, 12'd3,    4'h4, 12'd8,    1'b1, 3'd0},
            '{1'b0, 1'b1, 16'h0000, 12'd0,    4'h0, 12'd8,    1'b1, 3'd0},
            '{1'b0, 1'b0, 16'hB010, 12'd9,    4'h0, 12'd9,    1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hB902, 12'd20,   4'h8, 12'd22,   1'b1, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd23,   1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hB902, 12'd23,   4'h9, 12'd24,   1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hBAFE, 12'd24,   4'h4, 12'd22,   1'b1, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd23,   1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hBA10, 12'd23,   4'h0, 12'd24,   1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hB810, 12'd24,   4'h0, 12'd25,   1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hB014, 12'd10,   4'h0, 12'd30,   1'b1, 3'd1},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd31,   1'b0, 3'd1},
            '{1'b0, 1'b0, 16'hB00A, 12'd30,   4'h0, 12'd40,   1'b1, 3'd2},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd41,   1'b0, 3'd2},
            '{1'b0, 1'b0, 16'hA800, 12'd41,   4'h0, 12'd31,   1'b1, 3'd1},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd32,   1'b0, 3'd1},
            '{1'b0, 1'b0, 16'hA800, 12'd32,   4'h0, 12'd11,   1'b1, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'd12,   1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hA080, 12'd1,    4'h0, 12'hF81,  1'b1, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'hF82,  1'b0, 3'd0},
            '{1'b0, 1'b0, 16'hA002, 12'hFFF,  4'h0, 12'h001,  1'b1, 3'd0},
            '{1'b0, 1'b0, 16'h0000, 12'd0,    4'h0, 12'h002,  1'b0, 3'd0},
            '{1'b0, 1'b0, 16'h40F0, 12'd0,    4'h0, 12'h003,  1'b0, 3'd0}
        };
        bus.exec = 1'b0; bus.stall = 1'b0; bus.dec_ir = '0; bus.dec_pc = '0; bus.szcv = '0;
        #2;
        sb.push_back(mk(12'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
        check("reset_state");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 33; i++)
            apply(tbl[i].exec, tbl[i].stall, tbl[i].ir, tbl[i].dpc, tbl[i].szcv,
                  mk(tbl[i].pc, tbl[i].fl, 1'b1, 1'b0, tbl[i].cnt, 1'b0, 1'b0),
                  $sformatf("vec%0d", i));

        // five BALs into a four-deep stack: the oldest return address is lost
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 16'hB001, 12'(100 + 10 * i), 4'h0,
                  mk(12'(101 + 10 * i), 1'b1, 1'b1, 1'b0, 3'(i < 4 ? i + 1 : 4), 1'(i == 4), 1'b0),
                  $sformatf("bal%0d", i));
            apply(1'b0, 1'b0, 16'h0000, 12'd0, 4'h0,
                  mk(12'(102 + 10 * i), 1'b0, 1'b1, 1'b0, 3'(i < 4 ? i + 1 : 4), 1'(i == 4), 1'b0),
                  $sformatf("bal%0d_flush", i));
        end
        for (int k = 0; k < 4; k++) begin
            ret = 12'(141 - 10 * k);
            apply(1'b0, 1'b0, 16'hA800, 12'd0, 4'h0,
                  mk(ret, 1'b1, 1'b1, 1'b0, 3'(3 - k), 1'b1, 1'b0), $sformatf("br%0d", k));
            apply(1'b0, 1'b0, 16'h0000, 12'd0, 4'h0,
                  mk(ret + 12'd1, 1'b0, 1'b1, 1'b0, 3'(3 - k), 1'b1, 1'b0), $sformatf("br%0d_flush", k));
        end
        apply(1'b0, 1'b0, 16'hA800, 12'd0, 4'h0, mk(12'd113, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1), "br_empty");

        apply(1'b0, 1'b0, 16'hC0F0, 12'd7, 4'h0, mk(12'd113, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1), "halt");
        apply(1'b0, 1'b0, 16'h0000, 12'd0, 4'h0, mk(12'd113, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1), "halted_hold0");
        apply(1'b0, 1'b0, 16'h0000, 12'd0, 4'h0, mk(12'd113, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1), "halted_hold1");
        apply(1'b1, 1'b0, 16'h0000, 12'd0, 4'h0, mk(12'd113, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1), "resume");
        apply(1'b0, 1'b0, 16'h0000, 12'd0, 4'h0, mk(12'd114, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1), "resume_adv");
        apply(1'b1, 1'b0, 16'h0000, 12'd0, 4'h0, mk(12'd115, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1), "exec_in_run");

        // asynchronous reset landing in the middle of a flush cycle
        apply(1'b0, 1'b0, 16'hA010, 12'd0, 4'h0, mk(12'h010, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1), "b_before_reset");
        bus.dec_ir = '0;
        #3 reset = 1'b0;
        #1;
        sb.push_back(mk(12'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
        check("async_reset");
        @(posedge clock);
        #2 reset = 1'b1;
        apply(1'b0, 1'b0, 16'h0000, 12'd0, 4'h0, mk(12'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0), "idle_hold");
        apply(1'b1, 1'b0, 16'h0000, 12'd0, 4'h0, mk(12'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0), "restart");
        apply(1'b0, 1'b0, 16'h0000, 12'd0, 4'h0, mk(12'd1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0), "restart_adv");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Parametrised next-generation fetch/branch controller for the 5-stage pipelined processor.
- Owns the fetch PC, resolves B, conditional branch, BAL and BR from the decode stage, and generates the one-cycle wrong-path flush.
- Adds a multi-entry return-address stack (RAS) for nested BAL/BR, replacing the single link register.
- Adds a run/halt state machine with exec-driven resume.

Parameters:
PC_W, 12, width of fetch PC and return addresses (wraps mod 2^PC_W)
DATA_W, 16, instruction width (field positions below assume 16)
RAS_DEPTH, 4, number of RAS entries (>=2, power of two)
RESET_PC, 0, PC value loaded at reset

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
exec  in  1  start/resume pulse; sampled in IDLE and HALTED
stall  in  1  load-use hazard; freezes all state this cycle
dec_ir  in  DATA_W  instruction in decode stage
dec_pc  in  PC_W  PC of the decode-stage instruction
szcv  in  4  ALU flags {S,Z,C,V} for condition evaluation
fetch_pc  out  PC_W  address to instruction memory
flush  out  1  registered; decode-stage instruction is wrong-path, must become NOP
halting  out  1  high in HALTED
running  out  1  high in RUN
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  out  1  sticky; BAL pushed onto a full RAS
ras_underflow  out  1  sticky; BR executed on an empty RAS

Behaviour:
- Reset (reset=0, async): state=IDLE, fetch_pc=RESET_PC, flush=0, ras_count=0, both sticky flags=0, RAS contents don't-care. Applies at any point, including mid-branch.
- State machine:
  - IDLE: PC held. exec=1 -> RUN.
  - RUN: normal operation (below).
  - HALTED: PC held, flush=0. exec=1 -> RUN, resuming at the held fetch_pc.
  - exec is ignored in RUN.
- In RUN with stall=1: PC, flush, RAS, state and flags all hold.
- In RUN with stall=0 and flush=1: decode instruction is ignored; fetch_pc<=fetch_pc+1; flush<=0.
- In RUN with stall=0 and flush=0: decode dec_ir with this priority:
  1. B (ir[15:11]=10100), or a conditional branch whose condition is true:
     - BE (ir[15:8]=10111000): Z
     - BLT (10111001): S^V
     - BLE (10111010): Z|(S^V)
     - BNE (10111011): ~Z
     - Action: fetch_pc<=dec_pc+sext(ir[7:0]); flush<=1.
  2. BAL (ir[15:11]=10110): push dec_pc+1; fetch_pc<=dec_pc+sext(ir[7:0]); flush<=1.
     - RAS full: the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, ras_overflow<=1.
  3. BR (ir[15:11]=10101):
     - RAS non-empty: pop; fetch_pc<=popped value; flush<=1.
     - RAS empty: treated as NOP (fetch_pc+1, flush<=0), ras_underflow<=1.
  4. HALT (ir[15:14]=11 and ir[7:4]=1111): state<=HALTED; fetch_pc holds; flush<=0.
  5. Otherwise, including a not-taken conditional branch: fetch_pc<=fetch_pc+1; flush<=0.
- Branch latency: target appears on fetch_pc the cycle after the branch is in decode. Exactly one wrong-path instruction is flushed.
- Arithmetic: sext(ir[7:0]) is sign-extended to PC_W. All PC sums are truncated to PC_W (wrap-around).
- Push then pop: BAL followed later by BR returns to the BAL address +1. Nesting is LIFO up to RAS_DEPTH levels.
- Sticky flags clear only on reset.

Test Plan:
- Reset, exec pulse, stream of ALU ops from PC 0 -> fetch_pc 0,1,2,3 on successive cycles, flush=0; stall held high 2 cycles -> PC frozen for exactly 2 cycles.
- BNE at dec_pc=5, D=0xFC, Z=0 -> fetch_pc=1 next cycle, flush=1 for one cycle, then fetch_pc=2. Same with Z=1 -> fetch_pc simply increments, no flush.
- Nested BAL at PC 10 (D=+20), then BAL at 30 (D=+10), BR, BR -> pushes 11 and 31; BRs return to 31 then 11; ras_count 1,2,1,0.
- RAS_DEPTH=4, five consecutive BALs -> ras_overflow=1, ras_count=4; four BRs return the four newest addresses; fifth BR -> ras_underflow=1, PC increments, no flush.
- HALT at PC 7 -> halting=1, fetch_pc frozen; exec pulse -> running=1 and fetch_pc advances from the held value. reset low during a branch flush cycle -> immediately fetch_pc=RESET_PC, flush=0, state IDLE.
- B at dec_pc=0x001, D=0x80 (-128), PC_W=12 -> fetch_pc=0xF81 (wrap).
